// File: rtl/tcdm_bank_rr_arb.sv
// Per-bank round-robin request arbiter for the TCDM interconnect.
// Optional single request slot decouples the grant path from the bank.
module tcdm_bank_rr_arb #(
  parameter int NumIn         = 32,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32,
  parameter bit ReqReg        = 1'b0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumIn-1:0]                req_i,
  output logic [NumIn-1:0]                gnt_o,
  input  logic [NumIn*ReqDataWidth-1:0]   data_i,
  output logic                            req_o,
  input  logic                            gnt_i,
  output logic [ReqDataWidth-1:0]         data_o,
  input  logic [RespDataWidth-1:0]        rdata_i,
  output logic [RespDataWidth-1:0]        rdata_o
);

  localparam int IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [IdxW-1:0]         rr_q;
  logic [IdxW-1:0]         winner;
  logic                    found;
  logic                    load_ok;
  logic                    adv;
  logic [ReqDataWidth-1:0] win_data;

  // Scan from the pointer with an explicit wrap so no index >= NumIn
  always_comb begin : pick
    int idx;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NumIn; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NumIn) idx = idx - NumIn;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

  assign win_data = data_i[int'(winner)*ReqDataWidth +: ReqDataWidth];
  assign adv      = found & load_ok;

  always_comb begin
    gnt_o = '0;
    if (adv) gnt_o[winner] = 1'b1;
  end

  generate
    if (NumIn > 1) begin : g_rr
      logic [IdxW-1:0] rr_nxt;
      assign rr_nxt = (winner == IdxW'(NumIn - 1)) ?
                      '0 : winner + 1'b1;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rr_q <= '0;
        end else if (adv) begin
          rr_q <= rr_nxt;
        end
      end
    end else begin : g_no_rr
      assign rr_q = '0;
    end
  endgenerate

  generate
    if (ReqReg) begin : g_reg
      logic                    vld_q;
      logic [ReqDataWidth-1:0] data_q;

      // Slot may refill in the same cycle the bank drains it
      assign load_ok = !vld_q || gnt_i;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld_q  <= 1'b0;
          data_q <= '0;
        end else if (load_ok) begin
          vld_q <= found;
          if (found) data_q <= win_data;
        end
      end

      assign req_o  = vld_q;
      assign data_o = data_q;
    end else begin : g_comb
      assign load_ok = gnt_i;
      assign req_o   = found;
      assign data_o  = win_data;
    end
  endgenerate

  assign rdata_o = rdata_i;

endmodule

// File: tb/tb_tcdm_bank_rr_arb.sv
// Directed bench for tcdm_bank_rr_arb in three configurations.
// Instances: a = 4 masters comb, b = 4 masters slot, c = 3 masters comb.
module tb_tcdm_bank_rr_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]   a_req, a_gnt_o;
  logic [127:0] a_data;
  logic         a_req_o, a_gnt_i;
  logic [31:0]  a_data_o, a_rdata_i, a_rdata_o;

  logic [3:0]   b_req, b_gnt_o;
  logic [127:0] b_data;
  logic         b_req_o, b_gnt_i;
  logic [31:0]  b_data_o, b_rdata_i, b_rdata_o;

  logic [2:0]   c_req, c_gnt_o;
  logic [95:0]  c_data;
  logic         c_req_o, c_gnt_i;
  logic [31:0]  c_data_o, c_rdata_i, c_rdata_o;

  tcdm_bank_rr_arb #(
    .NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .ReqReg(1'b0)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt_o),
    .data_i(a_data), .req_o(a_req_o), .gnt_i(a_gnt_i),
    .data_o(a_data_o), .rdata_i(a_rdata_i), .rdata_o(a_rdata_o)
  );

  tcdm_bank_rr_arb #(
    .NumIn(4), .ReqDataWidth(32), .RespDataWidth(32), .ReqReg(1'b1)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt_o),
    .data_i(b_data), .req_o(b_req_o), .gnt_i(b_gnt_i),
    .data_o(b_data_o), .rdata_i(b_rdata_i), .rdata_o(b_rdata_o)
  );

  tcdm_bank_rr_arb #(
    .NumIn(3), .ReqDataWidth(32), .RespDataWidth(32), .ReqReg(1'b0)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(c_req), .gnt_o(c_gnt_o),
    .data_i(c_data), .req_o(c_req_o), .gnt_i(c_gnt_i),
    .data_o(c_data_o), .rdata_i(c_rdata_i), .rdata_o(c_rdata_o)
  );

  // Bank with 1-cycle read latency; master side expects data 2 cycles on
  logic [31:0] bank_rdata;
  logic [1:0]  rsp_pipe;
  always @(posedge clk) begin
    if (rst) begin
      rsp_pipe   <= 2'b00;
      bank_rdata <= 32'h0;
    end else begin
      if (b_req_o && b_gnt_i)
        bank_rdata <= (b_data_o == 32'h40) ? 32'hDEADBEEF : 32'h0;
      rsp_pipe <= {rsp_pipe[0], b_gnt_o[1]};
    end
  end
  assign b_rdata_i = bank_rdata;

  initial begin
    a_req = '0; a_gnt_i = 1'b0;
    b_req = '0; b_gnt_i = 1'b0;
    c_req = '0; c_gnt_i = 1'b0;
    a_data = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    b_data = {32'h0203, 32'h00A5, 32'h0201, 32'h0200};
    c_data = {32'h0302, 32'h0301, 32'h0300};
    a_rdata_i = 32'h12345678;
    c_rdata_i = 32'h0;

    rst = 1'b1;
    tick; tick;
    chk("rst_a_gnt", a_gnt_o, 32'h0);
    chk("rst_a_rr", u_a.rr_q, 32'h0);
    chk("rst_b_req", b_req_o, 32'h0);
    rst = 1'b0;

    // slot fills, then stalls
    b_req = 4'b1111; b_gnt_i = 1'b0;
    #1 chk("fill_gnt", b_gnt_o, 32'h1);
    tick;
    chk("full_req", b_req_o, 32'h1);
    chk("full_gnt", b_gnt_o, 32'h0);

    // reset mid-stream
    rst = 1'b1;
    #1 chk("mrst_req", b_req_o, 32'h0);
    tick; tick;
    chk("mrst_rr", u_b.rr_q, 32'h0);
    chk("mrst_req2", b_req_o, 32'h0);
    rst = 1'b0;
    b_gnt_i = 1'b1;
    #1 chk("post_rst_gnt", b_gnt_o, 32'h1);
    tick;
    chk("post_rst_data", b_data_o, 32'h200);
    chk("post_rst_rr", u_b.rr_q, 32'h1);

    // bank stall with master 2 in the slot
    b_req = 4'b0100; b_gnt_i = 1'b1;
    #1 chk("m2_gnt", b_gnt_o, 32'h4);
    tick;
    chk("m2_data", b_data_o, 32'hA5);
    b_req = 4'b1111; b_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", b_req_o, 32'h1);
      chk("stall_data", b_data_o, 32'hA5);
      chk("stall_gnt", b_gnt_o, 32'h0);
      chk("stall_rr", u_b.rr_q, 32'h3);
      tick;
    end
    b_gnt_i = 1'b1;
    #1 chk("unstall_gnt", b_gnt_o, 32'h8);
    tick;
    chk("unstall_data", b_data_o, 32'h203);
    b_req = 4'b0000;
    tick;
    chk("drain_req", b_req_o, 32'h0);

    // full contention, combinational path
    a_req = 4'b1111; a_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("cont_gnt", a_gnt_o, 32'(4'b0001 << (i % 4)));
      chk("cont_data", a_data_o, 32'h1000 + 32'(i % 4));
      chk("cont_req", a_req_o, 32'h1);
      tick;
    end

    // sparse requests
    a_req = 4'b1010;
    #1 chk("sp_gnt0", a_gnt_o, 32'h2);
    tick;
    #1 chk("sp_gnt1", a_gnt_o, 32'h8);
    tick;
    #1 chk("sp_gnt2", a_gnt_o, 32'h2);
    tick;
    a_req = 4'b1111; a_gnt_i = 1'b0;
    #1;
    chk("nogrant_gnt", a_gnt_o, 32'h0);
    chk("nogrant_req", a_req_o, 32'h1);
    chk("nogrant_rr", u_a.rr_q, 32'h2);
    chk("rdata_pass", a_rdata_o, 32'h12345678);
    a_req = 4'b0000; a_gnt_i = 1'b1;
    #1;
    chk("idle_gnt", a_gnt_o, 32'h0);
    chk("idle_req", a_req_o, 32'h0);

    // non-power-of-2 wrap
    c_req = 3'b100; c_gnt_i = 1'b1;
    #1 chk("np2_gnt", c_gnt_o, 32'h4);
    tick;
    chk("np2_rr", u_c.rr_q, 32'h0);
    c_req = 3'b111;
    #1 chk("np2_next", c_gnt_o, 32'h1);
    chk("np2_data", c_data_o, 32'h300);
    tick;

    // end-to-end read through the slot
    b_data[63:32] = 32'h40;
    b_req = 4'b0010; b_gnt_i = 1'b1;
    #1 chk("e2e_gnt", b_gnt_o, 32'h2);
    tick;
    b_req = 4'b0000;
    #1;
    chk("e2e_vld_early", rsp_pipe[1], 32'h0);
    chk("e2e_bank_req", b_req_o, 32'h1);
    tick;
    chk("e2e_vld", rsp_pipe[1], 32'h1);
    chk("e2e_rdata", b_rdata_o, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
